// File: rtl/fanin_pkg.sv
// Shared types for the round-robin request fan-in: payload container and pointer sizing.
package fanin_pkg;

  // Upper bounds for the payload container; the top zero-extends into these.
  localparam int unsigned ADDR_MAX = 64;
  localparam int unsigned DATA_MAX = 256;
  localparam int unsigned BE_MAX   = 32;
  localparam int unsigned ID_MAX   = 32;

  typedef struct packed {
    logic [ADDR_MAX-1:0] add;
    logic [DATA_MAX-1:0] wdata;
    logic                wen;
    logic [BE_MAX-1:0]   be;
    logic [ID_MAX-1:0]   ID;
  } payload_t;

  function automatic int unsigned ptr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority pick: first requester at or after rr_i, scanning cyclically.
module rr_priority_pick #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [PW-1:0]   rr_i,
  output logic [PW-1:0]   idx_o,
  output logic            vld_o
);

  int          c;
  logic [PW-1:0] ci;

  // Scan from farthest to nearest so the nearest requester is written last.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    c     = 0;
    ci    = '0;
    for (int k = int'(N_CH) - 1; k >= 0; k--) begin
      c = int'(rr_i) + k;
      if (c >= int'(N_CH)) c = c - int'(N_CH);
      ci = PW'(c);
      if (req_i[ci]) begin
        idx_o = ci;
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fanin_rr_req_n.sv
// N-channel round-robin request fan-in with optional single-entry output register slice.
module fanin_rr_req_n
  import fanin_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = 16,
  parameter int unsigned OUT_REG    = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_CH-1:0]                      data_req_i,
  input  logic [N_CH-1:0][ADDR_WIDTH-1:0]      data_add_i,
  input  logic [N_CH-1:0][DATA_WIDTH-1:0]      data_wdata_i,
  input  logic [N_CH-1:0]                      data_wen_i,
  input  logic [N_CH-1:0][BE_WIDTH-1:0]        data_be_i,
  input  logic [N_CH-1:0][ID_WIDTH-1:0]        data_ID_i,
  output logic [N_CH-1:0]                      data_gnt_o,
  output logic                                 data_req_o,
  output logic [ADDR_WIDTH-1:0]                data_add_o,
  output logic [DATA_WIDTH-1:0]                data_wdata_o,
  output logic                                 data_wen_o,
  output logic [BE_WIDTH-1:0]                  data_be_o,
  output logic [ID_WIDTH-1:0]                  data_ID_o,
  input  logic                                 data_gnt_i
);

  localparam int unsigned PW = ptr_w(N_CH);

  logic [PW-1:0] rr_q;
  logic [PW-1:0] win_idx;
  logic          win_vld;
  logic          acc_en;
  logic          acc;
  payload_t      win_pl;
  payload_t      out_pl;
  logic          unused_pad;

  rr_priority_pick #(
    .N_CH (N_CH),
    .PW   (PW)
  ) u_pick (
    .req_i (data_req_i),
    .rr_i  (rr_q),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  always_comb begin
    win_pl                        = '0;
    win_pl.add[ADDR_WIDTH-1:0]    = data_add_i[win_idx];
    win_pl.wdata[DATA_WIDTH-1:0]  = data_wdata_i[win_idx];
    win_pl.wen                    = data_wen_i[win_idx];
    win_pl.be[BE_WIDTH-1:0]       = data_be_i[win_idx];
    win_pl.ID[ID_WIDTH-1:0]       = data_ID_i[win_idx];
  end

  // Grant only goes to an actual requester; acc_en depends on the output path.
  assign acc        = win_vld & acc_en;
  assign data_gnt_o = acc ? (N_CH'(1) << win_idx) : '0;

  if (N_CH == 1) begin : g_rr1
    assign rr_q = '0;
  end else begin : g_rr
    logic [PW-1:0] rr_d;

    always_comb begin
      rr_d = rr_q;
      if (acc) rr_d = (win_idx == PW'(N_CH - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_q <= '0;
      else        rr_q <= rr_d;
    end
  end

  if (OUT_REG != 0) begin : g_reg
    logic     valid_q, valid_d;
    payload_t pl_q, pl_d;

    // Slot is free when empty or being drained this cycle: no bubble on back-to-back.
    assign acc_en = ~valid_q | data_gnt_i;

    always_comb begin
      valid_d = valid_q;
      pl_d    = pl_q;
      if (acc) begin
        valid_d = 1'b1;
        pl_d    = win_pl;
      end else if (data_gnt_i) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        pl_q    <= '0;
      end else begin
        valid_q <= valid_d;
        pl_q    <= pl_d;
      end
    end

    assign data_req_o = valid_q;
    assign out_pl     = pl_q;
  end else begin : g_comb
    assign acc_en     = data_gnt_i;
    assign data_req_o = |data_req_i;
    assign out_pl     = win_pl;
  end

  assign data_add_o   = out_pl.add[ADDR_WIDTH-1:0];
  assign data_wdata_o = out_pl.wdata[DATA_WIDTH-1:0];
  assign data_wen_o   = out_pl.wen;
  assign data_be_o    = out_pl.be[BE_WIDTH-1:0];
  assign data_ID_o    = out_pl.ID[ID_WIDTH-1:0];

  // Padding bits above the configured widths are always zero.
  assign unused_pad = ^out_pl;

endmodule

// File: tb/tb_fanin_rr_req_n.sv
// Directed bench: registered 4-ch, registered 3-ch and combinational 4-ch instances.
module tb_fanin_rr_req_n;
  localparam int AW = 16, DW = 16, BW = 2, IW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Shared 4-channel payload
  logic [3:0][AW-1:0] p_add;
  logic [3:0][DW-1:0] p_wdata;
  logic [3:0]         p_wen;
  logic [3:0][BW-1:0] p_be;
  logic [3:0][IW-1:0] p_id;
  // 3-channel payload
  logic [2:0][AW-1:0] q_add;
  logic [2:0][DW-1:0] q_wdata;
  logic [2:0]         q_wen;
  logic [2:0][BW-1:0] q_be;
  logic [2:0][IW-1:0] q_id;

  // u4r : N_CH=4, OUT_REG=1
  logic [3:0] a_req, a_gnt_o;
  logic       a_gnt_i, a_req_o, a_wen_o;
  logic [AW-1:0] a_add_o;
  logic [DW-1:0] a_wdata_o;
  logic [BW-1:0] a_be_o;
  logic [IW-1:0] a_id_o;
  // u3r : N_CH=3, OUT_REG=1
  logic [2:0] b_req, b_gnt_o;
  logic       b_gnt_i, b_req_o, b_wen_o;
  logic [AW-1:0] b_add_o;
  logic [DW-1:0] b_wdata_o;
  logic [BW-1:0] b_be_o;
  logic [IW-1:0] b_id_o;
  // u4c : N_CH=4, OUT_REG=0
  logic [3:0] c_req, c_gnt_o;
  logic       c_gnt_i, c_req_o, c_wen_o;
  logic [AW-1:0] c_add_o;
  logic [DW-1:0] c_wdata_o;
  logic [BW-1:0] c_be_o;
  logic [IW-1:0] c_id_o;

  fanin_rr_req_n #(.N_CH(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .ID_WIDTH(IW), .OUT_REG(1)) u4r (
    .clk(clk), .rst_n(rst_n), .data_req_i(a_req), .data_add_i(p_add), .data_wdata_i(p_wdata),
    .data_wen_i(p_wen), .data_be_i(p_be), .data_ID_i(p_id), .data_gnt_o(a_gnt_o), .data_req_o(a_req_o),
    .data_add_o(a_add_o), .data_wdata_o(a_wdata_o), .data_wen_o(a_wen_o), .data_be_o(a_be_o),
    .data_ID_o(a_id_o), .data_gnt_i(a_gnt_i));

  fanin_rr_req_n #(.N_CH(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .ID_WIDTH(IW), .OUT_REG(1)) u3r (
    .clk(clk), .rst_n(rst_n), .data_req_i(b_req), .data_add_i(q_add), .data_wdata_i(q_wdata),
    .data_wen_i(q_wen), .data_be_i(q_be), .data_ID_i(q_id), .data_gnt_o(b_gnt_o), .data_req_o(b_req_o),
    .data_add_o(b_add_o), .data_wdata_o(b_wdata_o), .data_wen_o(b_wen_o), .data_be_o(b_be_o),
    .data_ID_o(b_id_o), .data_gnt_i(b_gnt_i));

  fanin_rr_req_n #(.N_CH(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .ID_WIDTH(IW), .OUT_REG(0)) u4c (
    .clk(clk), .rst_n(rst_n), .data_req_i(c_req), .data_add_i(p_add), .data_wdata_i(p_wdata),
    .data_wen_i(p_wen), .data_be_i(p_be), .data_ID_i(p_id), .data_gnt_o(c_gnt_o), .data_req_o(c_req_o),
    .data_add_o(c_add_o), .data_wdata_o(c_wdata_o), .data_wen_o(c_wen_o), .data_be_o(c_be_o),
    .data_ID_o(c_id_o), .data_gnt_i(c_gnt_i));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int ch = 0; ch < 4; ch++) begin
      p_add[ch]   = AW'(16'h100 + ch);
      p_wdata[ch] = DW'(16'hA0 + ch);
      p_wen[ch]   = ch[0];
      p_be[ch]    = BW'(ch + 1);
      p_id[ch]    = IW'(8'h10 + ch);
    end
    for (int ch = 0; ch < 3; ch++) begin
      q_add[ch]   = AW'(16'h200 + ch);
      q_wdata[ch] = DW'(16'hB0 + ch);
      q_wen[ch]   = 1'b0;
      q_be[ch]    = '1;
      q_id[ch]    = IW'(8'h20 + ch);
    end
    a_req = '0; a_gnt_i = 1'b0;
    b_req = '0; b_gnt_i = 1'b0;
    c_req = '0; c_gnt_i = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_req_o", 64'(a_req_o), 64'd0);
    chk("rst_gnt_o", 64'(a_gnt_o), 64'd0);
    chk("rst_add_o", 64'(a_add_o), 64'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("post_rst_gnt", 64'(a_gnt_o), 64'd0);
    chk("post_rst_req_o", 64'(a_req_o), 64'd0);

    // All four requesting with downstream always ready: strict rotation, no bubbles
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin a_req = 4'b1111; a_gnt_i = 1'b1; end
      #1;
      chk($sformatf("rot_gnt%0d", k), 64'(a_gnt_o), 64'(4'b0001 << (k % 4)));
      chk($sformatf("rot_req_o%0d", k), 64'(a_req_o), 64'(k >= 1));
      if (k >= 1) begin
        chk($sformatf("rot_add%0d", k), 64'(a_add_o), 64'(16'h100 + (k - 1) % 4));
        chk($sformatf("rot_wdata%0d", k), 64'(a_wdata_o), 64'(16'hA0 + (k - 1) % 4));
        chk($sformatf("rot_wen%0d", k), 64'(a_wen_o), 64'(((k - 1) % 4) % 2));
        chk($sformatf("rot_be%0d", k), 64'(a_be_o), 64'((((k - 1) % 4) + 1) % 4));
        chk($sformatf("rot_id%0d", k), 64'(a_id_o), 64'(8'h10 + (k - 1) % 4));
      end
    end
    @(negedge clk); a_req = 4'b0000; #1;
    chk("drain_gnt", 64'(a_gnt_o), 64'd0);
    chk("drain_req_o", 64'(a_req_o), 64'd1);
    chk("drain_add", 64'(a_add_o), 64'h103);
    @(negedge clk); #1;
    chk("empty_req_o", 64'(a_req_o), 64'd0);

    // Stall: one grant pulse, payload held while downstream refuses
    @(negedge clk); a_req = 4'b0001; a_gnt_i = 1'b0; #1;
    chk("stall_first_gnt", 64'(a_gnt_o), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk($sformatf("stall_gnt%0d", k), 64'(a_gnt_o), 64'd0);
      chk($sformatf("stall_add%0d", k), 64'(a_add_o), 64'h100);
      chk($sformatf("stall_req_o%0d", k), 64'(a_req_o), 64'd1);
    end
    @(negedge clk); a_gnt_i = 1'b1; #1;
    chk("stall_release_gnt", 64'(a_gnt_o), 64'd1);
    @(negedge clk); a_req = 4'b0000; #1;
    chk("stall_drain_req_o", 64'(a_req_o), 64'd1);

    // Pointer now 1: accept ch1 -> 2; req 1001 -> ch3 wins, wrap to 0 -> ch0 wins -> 1
    @(negedge clk); a_req = 4'b0010; #1;
    chk("ptr_ch1_gnt", 64'(a_gnt_o), 64'b0010);
    @(negedge clk); a_req = 4'b1001; #1;
    chk("ptr2_1001_gnt", 64'(a_gnt_o), 64'b1000);
    @(negedge clk); #1;
    chk("ptr0_1001_gnt", 64'(a_gnt_o), 64'b0001);
    chk("ptr0_add", 64'(a_add_o), 64'h103);
    @(negedge clk); a_req = 4'b1111; #1;
    chk("ptr1_all_gnt", 64'(a_gnt_o), 64'b0010);
    chk("ptr1_add", 64'(a_add_o), 64'h100);
    @(negedge clk); a_req = 4'b0000; #1;
    @(negedge clk); #1;
    chk("ptr_empty_req_o", 64'(a_req_o), 64'd0);

    // Combinational path: stalled downstream, no grant, pointer unchanged
    @(negedge clk); c_req = 4'b0110; c_gnt_i = 1'b0; #1;
    chk("comb_req_o", 64'(c_req_o), 64'd1);
    chk("comb_stall_gnt", 64'(c_gnt_o), 64'd0);
    chk("comb_add", 64'(c_add_o), 64'h101);
    @(negedge clk); #1;
    chk("comb_stall_gnt2", 64'(c_gnt_o), 64'd0);
    chk("comb_add2", 64'(c_add_o), 64'h101);
    @(negedge clk); c_gnt_i = 1'b1; #1;
    chk("comb_gnt_ch1", 64'(c_gnt_o), 64'b0010);
    @(negedge clk); #1;
    chk("comb_gnt_ch2", 64'(c_gnt_o), 64'b0100);
    chk("comb_add_ch2", 64'(c_add_o), 64'h102);
    @(negedge clk); c_req = 4'b0000; #1;
    chk("comb_idle_req_o", 64'(c_req_o), 64'd0);
    chk("comb_idle_gnt", 64'(c_gnt_o), 64'd0);

    // N_CH=3 wrap from pointer 2 to 0
    @(negedge clk); b_req = 3'b001; b_gnt_i = 1'b1; #1;
    chk("n3_gnt0", 64'(b_gnt_o), 64'b001);
    @(negedge clk); b_req = 3'b010; #1;
    chk("n3_gnt1", 64'(b_gnt_o), 64'b010);
    @(negedge clk); b_req = 3'b100; #1;
    chk("n3_gnt2", 64'(b_gnt_o), 64'b100);
    @(negedge clk); b_req = 3'b111; #1;
    chk("n3_wrap_gnt", 64'(b_gnt_o), 64'b001);
    chk("n3_add", 64'(b_add_o), 64'h202);
    @(negedge clk); b_req = 3'b000; #1;

    // Reset mid-stream with a full slice
    @(negedge clk); a_req = 4'b0001; a_gnt_i = 1'b0; #1;
    chk("mid_gnt", 64'(a_gnt_o), 64'd1);
    @(negedge clk); a_req = 4'b0000; #1;
    chk("mid_full_req_o", 64'(a_req_o), 64'd1);
    #2 rst_n = 1'b0; #1;
    chk("mid_rst_req_o", 64'(a_req_o), 64'd0);
    chk("mid_rst_add", 64'(a_add_o), 64'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("mid_rel_gnt", 64'(a_gnt_o), 64'd0);
    chk("mid_rel_req_o", 64'(a_req_o), 64'd0);
    @(negedge clk); a_req = 4'b1111; a_gnt_i = 1'b1; #1;
    chk("mid_rel_ptr0", 64'(a_gnt_o), 64'b0001);
    @(negedge clk); a_req = 4'b0000; #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fanin_rr_req_n.md
FANIN_RR_REQ_N -- requirements
Module: fanin_rr_req_n

Interface
REQ-001 Parameter N_CH, default 4, SHALL set the number of request input channels, legal range 1..32.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the address width.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL set the write-data width.
REQ-004 Parameter BE_WIDTH, default DATA_WIDTH/8, SHALL set the byte-enable width.
REQ-005 Parameter ID_WIDTH, default 16, SHALL set the ID width.
REQ-006 Parameter OUT_REG, default 1, SHALL select the output path: 1 = registered output slice, 0 = combinational output path.
REQ-007 Port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-008 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-009 Port data_req_i, input, N_CH bits: per-channel request.
REQ-010 Ports data_add_i, data_wdata_i, data_wen_i, data_be_i and data_ID_i, all inputs, are N_CH x ADDR_WIDTH, N_CH x DATA_WIDTH, N_CH x 1, N_CH x BE_WIDTH and N_CH x ID_WIDTH respectively: per-channel payload.
REQ-011 Port data_gnt_o, output, N_CH bits: per-channel grant; at most one bit set.
REQ-012 Ports data_req_o, data_add_o, data_wdata_o, data_wen_o, data_be_o and data_ID_o are outputs carrying the merged request and its payload.
REQ-013 Port data_gnt_i, input, 1 bit: downstream grant.

Function
REQ-014 The rotating-priority pointer rr_q, max(1,$clog2(N_CH)) bits wide, SHALL identify the highest-priority channel.
REQ-015 The winner SHALL be the first channel with a set req when scanning cyclically from rr_q upward; no winner exists if all reqs are 0.
REQ-016 An accept SHALL be the cycle in which data_gnt_o[w] = 1.
REQ-017 On an accept, rr_q SHALL load w+1, wrapping from N_CH-1 to 0, including for non-power-of-2 N_CH.
REQ-018 Without an accept, rr_q SHALL hold its value.
REQ-019 OUT_REG=0: data_req_o = |data_req_i; payload outputs = winner payload; data_gnt_o[w] = data_gnt_i for the winner; latency 0.
REQ-020 OUT_REG=1: a single-entry slice (valid_q plus payload) SHALL drive data_req_o = valid_q and the payload outputs directly from flops.
REQ-021 OUT_REG=1: the slice can accept when ~valid_q | data_gnt_i; in that case data_gnt_o[winner] = 1, and the winner payload is captured with valid_q <= 1 at the next edge.
REQ-022 OUT_REG=1: when the slice drains (data_gnt_i & valid_q) with no winner present, valid_q SHALL be cleared to 0.
REQ-023 OUT_REG=1: a full slice with data_gnt_i = 0 SHALL hold its payload stable and assert no data_gnt_o.
REQ-024 OUT_REG=1: simultaneous drain and accept in one cycle SHALL sustain one transfer per cycle with no bubble.
REQ-025 OUT_REG=1: request-to-output latency SHALL be 1 cycle.
REQ-026 data_gnt_o SHALL never be asserted to a channel whose req is 0.
REQ-027 Fairness: with all N_CH channels requesting continuously and data_gnt_i = 1, each channel SHALL be granted exactly once per N_CH accepts.
REQ-028 N_CH=1: rr_q is constant 0; the block SHALL degenerate to a pass-through (OUT_REG=0) or a register slice (OUT_REG=1).
REQ-029 Request inputs are assumed held until granted; the block SHALL NOT depend on that assumption for correct grant generation.

Reset
REQ-030 While rst_n = 0, rr_q, valid_q and all registered payload SHALL be 0, independent of clk.
REQ-031 After reset, data_req_o = 0 (OUT_REG=1) and data_gnt_o = 0 until a request arrives.
REQ-032 Reset asserted mid-transfer SHALL discard the slice content; no grant SHALL be issued in the first cycle after rst_n rises unless a request is present.

Structure
REQ-033 Package fanin_pkg SHALL hold the payload struct typedef (add, wdata, wen, be, ID) and the pointer-width helper function.
REQ-034 Sub-module rr_priority_pick SHALL compute the combinational winner index and valid flag from req and rr_q.
REQ-035 The top level SHALL contain the pointer register, the payload mux and the output slice.

Verification
REQ-036 N_CH=4, OUT_REG=1, all req = 1111, data_gnt_i = 1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3; data_req_o high from cycle 1.
REQ-037 OUT_REG=1, req0 only, data_gnt_i = 0 for 5 cycles -> one data_gnt_o[0] pulse, data_add_o stable 5 cycles; data_gnt_i = 1 then -> next accept in the same cycle.
REQ-038 rr_q = 2, req = 1001 -> ch3 wins, rr_q becomes 0; next cycle ch0 wins, rr_q becomes 1.
REQ-039 N_CH=3, rr_q = 2, req = 100 accepted -> rr_q wraps to 0.
REQ-040 OUT_REG=0, req = 0110, data_gnt_i = 0 -> data_req_o = 1, data_gnt_o = 0000, rr_q unchanged.
REQ-041 rst_n low mid-stream with valid_q = 1 -> data_req_o = 0 immediately; rr_q = 0 after release.
